io_controller: RTL and testbench
================================

# io_controller

Memory-mapped I/O controller for the RISC-V core: it owns the `0x8xxxxxxx` address region that the memory-stage decoder routes through `io_trans` and `io_recv`. The block buffers traffic between the pipeline and the UART in two small FIFOs. It keeps the cycle and retired-instruction counters and returns read data with the same one-cycle latency as dmem. The writeback mux selects its output whenever the preceding load had `addr[31:28] == 4'b1000`.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: entries in each of the TX and RX byte FIFOs; power of two, ≥ 2.

Ports:
- `clk` in 1: core clock; one clock domain, no crossings.
- `rst` in 1: synchronous, active-high reset.
- `addr` in 32: memory-stage address; only `addr[7:0]` is decoded, because region select is already done upstream.
- `io_trans` in 4: write byte mask, already gated by `haz_ena` and region upstream; any bit set means a write.
- `io_recv` in 1: read strobe for this region.
- `wdata` in 32: store data, already lane-shifted (`mem_in`).
- `inst_retire` in 1: one instruction retires this cycle.
- `io_dout` out 32: registered read data.
- `uart_tx_data` out 8: head of the TX FIFO.
- `uart_tx_valid` out 1: TX FIFO not empty.
- `uart_tx_ready` in 1: UART accepts a byte.
- `uart_rx_data` in 8: received byte.
- `uart_rx_valid` in 1: received byte available.
- `uart_rx_ready` out 1: RX FIFO not full.

## Operation
Register map, by `addr[7:0]`:
- `0x00` control (RO):
  - bit0 = `tx_ready` (TX FIFO not full).
  - bit1 = `rx_valid` (RX FIFO not empty).
  - bit2 = `tx_overflow`, sticky.
  - Other bits read 0.
- `0x04` RX data (RO): `{24'b0, rx_head}`. A read with `rx_valid` set pops one entry. A read with the FIFO empty returns 0 and pops nothing.
- `0x08` TX data (WO): a write with `io_trans[0]` set pushes `wdata[7:0]`. A push while the TX FIFO is full is dropped and sets `tx_overflow`.
- `0x0C` write (any mask): clears `tx_overflow`.
- `0x10` cycle counter (RO): increments every cycle and wraps modulo 2^32.
- `0x14` instruction counter (RO): increments in cycles with `inst_retire` and wraps modulo 2^32.
- `0x18` counter reset (WO): any write zeroes both counters.
- Unmapped reads return 0. Writes to RO or unmapped offsets have no effect.

UART side:
- A TX pop occurs when `uart_tx_valid && uart_tx_ready`.
- An RX push occurs when `uart_rx_valid && uart_rx_ready`.

Fullness and emptiness come from the registered occupancy count only. A push to a full FIFO is rejected even if a pop happens in the same cycle. A pop from an empty FIFO is a no-op.

## Timing
- Reset values:
  - `io_dout` = 0.
  - Both FIFOs empty, so `uart_tx_valid` = 0 and `uart_rx_ready` = 1.
  - Counters = 0; `tx_overflow` = 0.
- Read latency: `io_recv` in cycle N puts data on `io_dout` in cycle N+1. `io_dout` holds its last value while `io_recv` is low.
- Read data reflects state before the cycle-N edge. A counter read in the same cycle as a counter-reset write returns the pre-reset value.
- RX pop and an RX data read take effect at the same edge. A UART push in the same cycle onto an empty RX FIFO is accepted, but the read still returns 0.
- A TX write at edge N gives `uart_tx_valid` = 1 in cycle N+1, with `uart_tx_data` taken combinationally from the head entry.
- Counter reset and increment in the same cycle: reset wins, and the counter is 0 after the edge.
- Reset mid-operation: the FIFOs flush, bytes in flight are discarded, and the outputs take their reset values after the edge.
- Control-status bits follow FIFO occupancy one cycle after each push or pop edge.

## Structure
- A shared package (`io_pkg`) holds:
  - the register offset constants `IO_CTRL`, `IO_RX_DATA`, `IO_TX_DATA`, `IO_OVF_CLR`, `IO_CYCLE_CNT`, `IO_INST_CNT`, `IO_CNT_RST`;
  - the control bit indices;
  - the region code `4'b1000`, which the upstream decoder also uses.
- One sub-module, `io_fifo`:
  - parameterised by `WIDTH` and `DEPTH`, instantiated twice;
  - circular buffer with a `$clog2(DEPTH)+1` count;
  - ports `push`, `pop`, `din`, `dout`, `full`, `empty`.
- The top level contains only the address decode, the counters, the overflow flag and the registered read mux.

## Test plan
- Reset, then read `0x00` → `io_dout` = `0x00000001`. Read `0x10` with N cycles between the two reads → values differ by N, within 1 cycle.
- Write `0x41`, `0x42`, `0x43` to `0x08` with `uart_tx_ready` = 0 → `uart_tx_valid` = 1 with `uart_tx_data` = `0x41`. Raise `uart_tx_ready` → bytes leave in order, then `uart_tx_valid` drops.
- Hold `uart_tx_ready` = 0 and write 5 bytes → first 4 kept, 5th dropped. Control reads `0x4`, since `tx_ready` is 0 and overflow is set. Write `0x0C` → bit2 clears.
- UART pushes `0x55` and `0xAA`; the CPU reads `0x04` three times → reads return `0x55`, `0xAA`, then 0. Control reads `0x1` at the end.
- Pulse `inst_retire` 7 times, then read `0x14` → 7. Write `0x18` in the same cycle as an `inst_retire` → the next read of `0x14` returns 0.
- Assert `rst` mid-stream with 2 bytes in each FIFO → both FIFOs are empty next cycle, `uart_tx_valid` = 0 and `uart_rx_ready` = 1.

Source files
------------

// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped I/O region: register offsets,
// control-status bit positions and the region code seen by the upstream decoder.
package io_pkg;

    // addr[31:28] value that routes a memory-stage access to this block
    localparam logic [3:0] IO_REGION = 4'b1000;

    // Register offsets, decoded from addr[7:0]
    localparam logic [7:0] IO_CTRL      = 8'h00;
    localparam logic [7:0] IO_RX_DATA   = 8'h04;
    localparam logic [7:0] IO_TX_DATA   = 8'h08;
    localparam logic [7:0] IO_OVF_CLR   = 8'h0C;
    localparam logic [7:0] IO_CYCLE_CNT = 8'h10;
    localparam logic [7:0] IO_INST_CNT  = 8'h14;
    localparam logic [7:0] IO_CNT_RST   = 8'h18;

    // Control register bit indices
    localparam int unsigned CTRL_TX_READY   = 0;
    localparam int unsigned CTRL_RX_VALID   = 1;
    localparam int unsigned CTRL_TX_OVERFLOW = 2;

    function automatic logic [31:0] ctrl_word(input logic tx_ready, input logic rx_valid,
                                              input logic tx_overflow);
        logic [31:0] w;
        w = '0;
        w[CTRL_TX_READY]    = tx_ready;
        w[CTRL_RX_VALID]    = rx_valid;
        w[CTRL_TX_OVERFLOW] = tx_overflow;
        return w;
    endfunction

endpackage

// File: rtl/io_fifo.sv
// Circular-buffer FIFO with a registered occupancy count; full/empty derive
// from the count alone, so a push to a full FIFO is refused even alongside a pop.
module io_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage carries no reset; only the pointers and count define validity
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_controller.sv
// Memory-mapped I/O controller: UART TX/RX FIFOs, cycle and retired-instruction
// counters, and a one-cycle registered read mux matching dmem latency.
module io_controller
    import io_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [3:0]  io_trans,
    input  logic        io_recv,
    input  logic [31:0] wdata,
    input  logic        inst_retire,
    output logic [31:0] io_dout,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);

    logic [7:0]  offset;
    logic        wr_en;
    logic        tx_push;
    logic        tx_pop;
    logic        tx_full;
    logic        tx_empty;
    logic        rx_push;
    logic        rx_pop;
    logic        rx_full;
    logic        rx_empty;
    logic [7:0]  rx_head;
    logic        cnt_rst;
    logic        ovf_clr;
    logic        tx_overflow;
    logic [31:0] cycle_cnt;
    logic [31:0] inst_cnt;
    logic [31:0] rdata;
    logic        unused_bits;

    // Region select happens upstream; only the low byte is decoded here
    assign offset      = addr[7:0];
    assign wr_en       = |io_trans;
    assign unused_bits = ^{addr[31:8], wdata[31:8]};

    assign tx_push = wr_en && (offset == IO_TX_DATA) && io_trans[0];
    assign tx_pop  = uart_tx_valid && uart_tx_ready;
    assign rx_push = uart_rx_valid && uart_rx_ready;
    assign rx_pop  = io_recv && (offset == IO_RX_DATA) && !rx_empty;
    assign cnt_rst = wr_en && (offset == IO_CNT_RST);
    assign ovf_clr = wr_en && (offset == IO_OVF_CLR);

    assign uart_tx_valid = !tx_empty;
    assign uart_rx_ready = !rx_full;

    io_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (wdata[7:0]),
        .dout  (uart_tx_data),
        .full  (tx_full),
        .empty (tx_empty)
    );

    io_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (uart_rx_data),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // Read data is formed from pre-edge state, so counter reads see pre-reset values
    always_comb begin
        rdata = '0;
        case (offset)
            IO_CTRL:      rdata = ctrl_word(!tx_full, !rx_empty, tx_overflow);
            IO_RX_DATA:   rdata = rx_empty ? 32'h0 : {24'h0, rx_head};
            IO_CYCLE_CNT: rdata = cycle_cnt;
            IO_INST_CNT:  rdata = inst_cnt;
            default:      rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            io_dout     <= '0;
            tx_overflow <= 1'b0;
            cycle_cnt   <= '0;
            inst_cnt    <= '0;
        end else begin
            if (io_recv) begin
                io_dout <= rdata;
            end

            if (tx_push && tx_full) begin
                tx_overflow <= 1'b1;
            end else if (ovf_clr) begin
                tx_overflow <= 1'b0;
            end

            // Counter reset takes priority over a same-cycle increment
            if (cnt_rst) begin
                cycle_cnt <= '0;
                inst_cnt  <= '0;
            end else begin
                cycle_cnt <= cycle_cnt + 32'd1;
                if (inst_retire) begin
                    inst_cnt <= inst_cnt + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_io_controller.sv
// Directed bench for io_controller: register reads, UART FIFO traffic,
// overflow handling, counters and mid-stream reset.
module tb_io_controller;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [3:0]  io_trans;
    logic        io_recv;
    logic [31:0] wdata;
    logic        inst_retire;
    logic [31:0] io_dout;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;

    int n_cmp;
    int n_bad;

    logic [31:0] rv;
    logic [31:0] c1;
    logic [31:0] c2;

    io_controller #(
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .addr          (addr),
        .io_trans      (io_trans),
        .io_recv       (io_recv),
        .wdata         (wdata),
        .inst_retire   (inst_retire),
        .io_dout       (io_dout),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 ns after a rising edge; outputs are sampled there too
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        addr    = {24'h800000, a};
        io_recv = 1'b1;
        tick();
        io_recv = 1'b0;
        d = io_dout;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
        addr     = {24'h800000, a};
        wdata    = d;
        io_trans = m;
        tick();
        io_trans = 4'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        addr = 32'h0;
        io_trans = 4'h0;
        io_recv = 1'b0;
        wdata = 32'h0;
        inst_retire = 1'b0;
        uart_tx_ready = 1'b0;
        uart_rx_data = 8'h0;
        uart_rx_valid = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_dout", io_dout, 32'h0);
        check("rst_tx_valid", {31'h0, uart_tx_valid}, 32'h0);
        check("rst_rx_ready", {31'h0, uart_rx_ready}, 32'h1);
        rst = 1'b0;
        tick();

        rd(8'h00, rv);
        check("ctrl_after_rst", rv, 32'h1);

        // Cycle counter: 6 edges separate the two sampled values
        rd(8'h10, c1);
        repeat (5) tick();
        rd(8'h10, c2);
        check("cycle_delta", c2 - c1, 32'd6);

        // TX ordering
        wr(8'h08, 32'h41, 4'h1);
        wr(8'h08, 32'h42, 4'h1);
        wr(8'h08, 32'h43, 4'h1);
        check("tx_valid_3", {31'h0, uart_tx_valid}, 32'h1);
        check("tx_head_41", {24'h0, uart_tx_data}, 32'h41);
        rd(8'h00, rv);
        check("ctrl_tx3", rv, 32'h1);
        uart_tx_ready = 1'b1;
        check("tx_out_41", {24'h0, uart_tx_data}, 32'h41);
        tick();
        check("tx_out_42", {24'h0, uart_tx_data}, 32'h42);
        tick();
        check("tx_out_43", {24'h0, uart_tx_data}, 32'h43);
        tick();
        check("tx_drained", {31'h0, uart_tx_valid}, 32'h0);
        uart_tx_ready = 1'b0;

        // TX overflow: fifth byte dropped
        for (int i = 1; i <= 5; i++) begin
            wr(8'h08, 32'(i), 4'h1);
        end
        rd(8'h00, rv);
        check("ctrl_ovf", rv, 32'h4);
        wr(8'h0C, 32'h0, 4'hF);
        rd(8'h00, rv);
        check("ctrl_ovf_clr", rv, 32'h0);
        uart_tx_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("ovf_out_%0d", i), {24'h0, uart_tx_data}, 32'(i));
            tick();
        end
        check("ovf_drained", {31'h0, uart_tx_valid}, 32'h0);
        uart_tx_ready = 1'b0;

        // RX path
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'h55;
        tick();
        uart_rx_data  = 8'hAA;
        tick();
        uart_rx_valid = 1'b0;
        rd(8'h04, rv);
        check("rx_55", rv, 32'h55);
        rd(8'h04, rv);
        check("rx_aa", rv, 32'hAA);
        rd(8'h04, rv);
        check("rx_empty_0", rv, 32'h0);
        rd(8'h00, rv);
        check("ctrl_rx_end", rv, 32'h1);

        // Push onto empty RX while the CPU reads: read returns 0, byte kept
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'h77;
        rd(8'h04, rv);
        uart_rx_valid = 1'b0;
        check("rx_same_cycle", rv, 32'h0);
        rd(8'h04, rv);
        check("rx_77", rv, 32'h77);

        // Counters
        wr(8'h18, 32'h0, 4'h1);
        rd(8'h10, rv);
        check("cycle_after_clr", rv, 32'h0);
        for (int i = 0; i < 7; i++) begin
            inst_retire = 1'b1;
            tick();
            inst_retire = 1'b0;
            tick();
        end
        rd(8'h14, rv);
        check("inst_7", rv, 32'd7);
        tick();
        check("dout_hold", io_dout, 32'd7);
        rd(8'h1C, rv);
        check("unmapped_0", rv, 32'h0);
        inst_retire = 1'b1;
        wr(8'h18, 32'h0, 4'h8);
        inst_retire = 1'b0;
        rd(8'h14, rv);
        check("inst_rst_wins", rv, 32'h0);

        // Mid-stream reset with traffic in both FIFOs
        wr(8'h08, 32'hA1, 4'h1);
        wr(8'h08, 32'hA2, 4'h1);
        uart_rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            uart_rx_data = 8'hB0 + 8'(i);
            tick();
        end
        uart_rx_valid = 1'b0;
        check("rx_full_ready", {31'h0, uart_rx_ready}, 32'h0);
        rd(8'h00, rv);
        check("ctrl_pre_rst", rv, 32'h3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_tx_valid", {31'h0, uart_tx_valid}, 32'h0);
        check("mid_rst_rx_ready", {31'h0, uart_rx_ready}, 32'h1);
        check("mid_rst_dout", io_dout, 32'h0);
        rd(8'h00, rv);
        check("mid_rst_ctrl", rv, 32'h1);
        rd(8'h04, rv);
        check("mid_rst_rx", rv, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
